// File: rtl/dump_memory.sv
// dump_memory: single-port memory with pipelined CPU reads and a valid/ready full-memory dump engine
module dump_memory #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  busy,
   input  logic                  dump_start,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [ADDR_WIDTH-1:0] dump_addr,
   output logic [DATA_WIDTH-1:0] dump_data,
   output logic                  dump_done
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] DRAIN = 3'd1;
   localparam logic [2:0] LOAD  = 3'd2;
   localparam logic [2:0] OUT   = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;
   localparam logic [ADDR_WIDTH-1:0] LAST = '1;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
   logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
   logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
   logic [DATA_WIDTH-1:0] rd_dat_q [RD_LATENCY];
   logic [DATA_WIDTH-1:0] rd_dat_d [RD_LATENCY];
   logic                  acc_rd, acc_wr;

   assign busy       = state_q != IDLE;
   assign acc_rd     = req && !busy && !rst && !write;
   assign acc_wr     = req && !busy && !rst && write;
   assign rvalid     = rd_vld_q[RD_LATENCY-1];
   assign rdata      = rd_dat_q[RD_LATENCY-1];
   assign dump_valid = state_q == OUT;
   assign dump_done  = state_q == DONE;
   assign dump_addr  = dump_addr_q;
   assign dump_data  = dump_data_q;

   // CPU writes land at the accept edge; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (acc_wr) mem[addr] <= wdata;
   end

   // read pipeline: data captured at accept, each stage only loads when a valid read moves in so the last stage holds
   always_comb begin
      rd_vld_d[0] = acc_rd;
      rd_dat_d[0] = acc_rd ? mem[addr] : rd_dat_q[0];
      for (int i = 1; i < RD_LATENCY; i++) begin
         rd_vld_d[i] = rd_vld_q[i-1];
         rd_dat_d[i] = rd_vld_q[i-1] ? rd_dat_q[i-1] : rd_dat_q[i];
      end
   end

   // dump sequencer: drain in-flight reads, then alternate LOAD/OUT per word until the all-ones address transfers
   always_comb begin
      state_d     = state_q;
      dump_addr_d = dump_addr_q;
      dump_data_d = dump_data_q;
      case (state_q)
         IDLE:  state_d = dump_start ? DRAIN : IDLE;
         DRAIN: state_d = |rd_vld_q ? DRAIN : LOAD;
         LOAD: begin
            dump_data_d = mem[dump_addr_q];
            state_d     = OUT;
         end
         OUT: begin
            if (dump_ready) begin
               state_d     = dump_addr_q == LAST ? DONE : LOAD;
               dump_addr_d = dump_addr_q == LAST ? dump_addr_q : dump_addr_q + 1'b1;
            end
         end
         DONE: begin
            state_d     = IDLE;
            dump_addr_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers with synchronous reset; reset abandons any dump and empties the read pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         dump_addr_q <= '0;
         dump_data_q <= '0;
         rd_vld_q    <= '0;
         for (int i = 0; i < RD_LATENCY; i++) rd_dat_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         dump_addr_q <= dump_addr_d;
         dump_data_q <= dump_data_d;
         rd_vld_q    <= rd_vld_d;
         for (int i = 0; i < RD_LATENCY; i++) rd_dat_q[i] <= rd_dat_d[i];
      end
   end
endmodule

// File: tb/tb_dump_memory.sv
// tb_dump_memory: three instances (read latency 1, 2, 3) on shared stimulus, checked against a per-instance model
module tb_dump_memory;
   typedef struct { int k; int due; logic [7:0] data; } rd_t;
   typedef struct { int k; logic [7:0] addr; logic [7:0] data; } dp_t;
   typedef struct { logic req; logic write; logic [7:0] addr; logic [7:0] wdata; logic exp_rv; logic [7:0] exp_rd; } vec_t;

   logic       clk = 0;
   logic       rst = 1;
   logic       req = 0, write = 0, dump_start = 0, dump_ready = 0;
   logic [7:0] addr = 0, wdata = 0;
   logic [7:0] rdata [3];
   logic       rvalid [3];
   logic       busy [3];
   logic       dump_valid [3];
   logic [7:0] dump_addr [3];
   logic [7:0] dump_data [3];
   logic       dump_done [3];

   rd_t        rq[$];
   dp_t        dq[$];
   logic [7:0] mdl [3][256];
   bit         eb [3], ed [3], hold [3];
   logic [7:0] last_rd [3];
   int         cyc = 0, passed = 0, total = 0, ri, di;
   vec_t       vt [15];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dump_memory #(.RD_LATENCY(g + 1)) u_dut (
         .clk(clk), .rst(rst), .req(req), .write(write), .addr(addr), .wdata(wdata),
         .rdata(rdata[g]), .rvalid(rvalid[g]), .busy(busy[g]),
         .dump_start(dump_start), .dump_valid(dump_valid[g]), .dump_ready(dump_ready),
         .dump_addr(dump_addr[g]), .dump_data(dump_data[g]), .dump_done(dump_done[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d, input logic ds);
      @(posedge clk);
      #1;
      req = r; write = w; addr = a; wdata = d; dump_start = ds;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy[0] || busy[1] || busy[2]) && n < 3000);
      chk("idle_wait", busy[0] | busy[1] | busy[2], 0);
   endtask

   // scoreboard monitor: checks every instance each cycle, pushes expectations on accepted stimulus
   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
         rq.delete();
         dq.delete();
         for (int k = 0; k < 3; k++) begin
            eb[k] = 0; ed[k] = 0; hold[k] = 0; last_rd[k] = '0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            chk("busy", busy[k], eb[k]);
            chk("dump_done", dump_done[k], ed[k]);
            if (hold[k]) chk("hold_valid", dump_valid[k], 1);
            if (!eb[k]) begin
               chk("idle_dump_addr", dump_addr[k], 0);
               chk("idle_dump_valid", dump_valid[k], 0);
            end
            ri = -1;
            foreach (rq[i]) if (ri < 0 && rq[i].k == k) ri = i;
            if (rvalid[k]) begin
               if (ri < 0) chk("rvalid_spurious", rvalid[k], 0);
               else begin
                  chk("rd_cycle", cyc, rq[ri].due);
                  chk("rdata", rdata[k], rq[ri].data);
                  last_rd[k] = rq[ri].data;
                  rq.delete(ri);
               end
            end else begin
               if (ri >= 0 && rq[ri].due <= cyc) begin
                  chk("rvalid_missing", rvalid[k], 1);
                  rq.delete(ri);
               end
               chk("rdata_hold", rdata[k], last_rd[k]);
            end
            if (req && !eb[k]) begin
               if (write) mdl[k][addr] = wdata;
               else rq.push_back('{k, cyc + k + 1, mdl[k][addr]});
            end
            if (eb[k] && ed[k]) eb[k] = 0;
            else if (!eb[k] && dump_start) begin
               eb[k] = 1;
               for (int a = 0; a < 256; a++) dq.push_back('{k, a[7:0], mdl[k][a]});
            end
            ed[k] = 0;
            if (dump_valid[k]) begin
               di = -1;
               foreach (dq[i]) if (di < 0 && dq[i].k == k) di = i;
               if (di < 0) chk("dump_spurious", dump_valid[k], 0);
               else begin
                  chk("dump_addr", dump_addr[k], dq[di].addr);
                  chk("dump_data", dump_data[k], dq[di].data);
                  if (dump_ready) begin
                     ed[k] = dq[di].addr == 8'hFF;
                     dq.delete(di);
                  end
               end
            end
            hold[k] = dump_valid[k] && !dump_ready;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      vt[0]  = '{1, 1, 8'h10, 8'hA5, 0, 8'h00};
      vt[1]  = '{1, 0, 8'h10, 8'h00, 0, 8'h00};
      vt[2]  = '{0, 0, 8'h00, 8'h00, 1, 8'hA5};
      vt[3]  = '{0, 0, 8'h00, 8'h00, 0, 8'hA5};
      vt[4]  = '{1, 1, 8'h00, 8'h11, 0, 8'hA5};
      vt[5]  = '{1, 1, 8'h01, 8'h22, 0, 8'hA5};
      vt[6]  = '{1, 1, 8'h02, 8'h33, 0, 8'hA5};
      vt[7]  = '{1, 1, 8'h03, 8'h44, 0, 8'hA5};
      vt[8]  = '{1, 0, 8'h00, 8'h00, 0, 8'hA5};
      vt[9]  = '{1, 0, 8'h01, 8'h00, 1, 8'h11};
      vt[10] = '{1, 0, 8'h02, 8'h00, 1, 8'h22};
      vt[11] = '{1, 0, 8'h03, 8'h00, 1, 8'h33};
      vt[12] = '{0, 0, 8'h00, 8'h00, 1, 8'h44};
      vt[13] = '{0, 0, 8'h00, 8'h00, 0, 8'h44};
      vt[14] = '{0, 0, 8'h00, 8'h00, 0, 8'h44};

      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_rvalid", rvalid[0], 0);
      chk("rst_rdata", rdata[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_dump_valid", dump_valid[0], 0);
      chk("rst_dump_addr", dump_addr[0], 0);
      chk("rst_dump_done", dump_done[0], 0);

      foreach (vt[i]) begin
         drive(vt[i].req, vt[i].write, vt[i].addr, vt[i].wdata, 0);
         @(negedge clk);
         chk("vec_rvalid", rvalid[0], vt[i].exp_rv);
         chk("vec_rdata", rdata[0], vt[i].exp_rd);
      end

      for (int i = 0; i < 256; i++) drive(1, 1, i[7:0], i[7:0] ^ 8'hFF, 0);
      drive(0, 0, 0, 0, 0);

      dump_ready = 1;
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      wait_idle();

      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!(dump_valid[0] && dump_addr[0] == 8'h07) && n < 2000);
      chk("bp_reach", dump_addr[0], 8'h07);
      dump_ready = 0;
      repeat (5) @(posedge clk);
      #1 dump_ready = 1;
      @(negedge clk);
      chk("bp_valid", dump_valid[0], 1);
      chk("bp_addr", dump_addr[0], 8'h07);
      chk("bp_data", dump_data[0], 8'hF8);
      @(negedge clk);
      chk("bp_next_valid", dump_valid[0], 0);
      chk("bp_next_addr", dump_addr[0], 8'h08);
      wait_idle();

      drive(1, 0, 8'h10, 0, 1);
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("drain_busy", busy[1], 1);
      chk("drain_rvalid_early", rvalid[1], 0);
      @(negedge clk);
      chk("drain_rvalid", rvalid[1], 1);
      chk("drain_rdata", rdata[1], 8'hEF);
      chk("drain_busy2", busy[1], 1);
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!dump_valid[2] && n < 100);
      chk("all_busy", busy[0] & busy[1] & busy[2], 1);
      drive(1, 1, 8'h20, 8'h99, 0);
      drive(1, 1, 8'h20, 8'h99, 0);
      drive(0, 0, 0, 0, 0);
      wait_idle();
      drive(1, 0, 8'h20, 0, 0);
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("busy_write_ignored", rdata[0], 8'hDF);

      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!(dump_valid[0] && dump_addr[0] == 8'h40) && n < 2000);
      chk("rst_reach", dump_addr[0], 8'h40);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("abort_busy", busy[0], 0);
      chk("abort_valid", dump_valid[0], 0);
      chk("abort_done", dump_done[0], 0);
      chk("abort_addr", dump_addr[0], 0);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      wait_idle();
      repeat (5) @(negedge clk);

      chk("rq_empty", rq.size(), 0);
      chk("dq_empty", dq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dump_memory.md
Name: dump_memory

Overview:
- Parametrised single-port synchronous memory for the CPU datapath. Successor to the plain CPU memory model.
- Adds configurable read latency with a read-valid strobe, and a CPU-port busy/stall indication.
- Adds a hardware dump engine that streams every word out over a valid/ready channel. Benches and debug logic capture memory contents through this channel instead of peeking at the array.
- Sits between the cpu block and the bench/debug capture logic.

Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 8, word width in bits.
- RD_LATENCY, 1, read latency in cycles from accepted read to rvalid; legal range 1..4.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  CPU access request.
- write  input  1  1 = write, 0 = read; qualified by req.
- addr  input  ADDR_WIDTH  CPU word address.
- wdata  input  DATA_WIDTH  CPU write data.
- rdata  output  DATA_WIDTH  read data; holds last returned value.
- rvalid  output  1  one-cycle strobe; rdata is valid this cycle.
- busy  output  1  1 = CPU port stalled; req is ignored.
- dump_start  input  1  request a full-memory dump.
- dump_valid  output  1  dump word available.
- dump_ready  input  1  consumer accepts the dump word.
- dump_addr  output  ADDR_WIDTH  address of the current dump word.
- dump_data  output  DATA_WIDTH  contents of mem[dump_addr].
- dump_done  output  1  one-cycle pulse after the last word transfers.

Behaviour:
- Storage array is named mem. It is not cleared by rst, so contents survive reset. Benches preload it with $readmemh via the hierarchical path.
- Reset values: rdata=0, rvalid=0, busy=0, dump_valid=0, dump_addr=0, dump_data=0, dump_done=0. State = IDLE; read pipeline is emptied.
- An access is accepted when req=1 and busy=0.
  - Accepted write: mem[addr] <= wdata at that edge.
  - Accepted read: the value is captured at the accept edge. rvalid=1 and rdata show it RD_LATENCY cycles after the accept cycle.
- Reads are fully pipelined: one accepted read per cycle, returned in order.
- A write at cycle N followed by a read of the same address at cycle N+1 returns the new data.
- rvalid is high only for the single cycle its data appears.
- When busy=1, req is ignored: no write occurs and no rvalid is produced for it.
- State machine:
  - IDLE: busy=0. dump_start=1 -> DRAIN. A req in the same cycle is still accepted and serviced.
  - DRAIN: busy=1. Stays while any read is in flight; its rvalid still fires. Pipeline empty -> LOAD. Minimum 1 cycle.
  - LOAD: busy=1. dump_data <= mem[dump_addr] -> OUT.
  - OUT: busy=1, dump_valid=1. dump_addr and dump_data are held stable until dump_ready=1.
    - Transfer (valid & ready) with dump_addr != all-ones: dump_addr+1, -> LOAD.
    - Transfer at dump_addr == 2^ADDR_WIDTH-1 -> DONE.
  - DONE: busy=1, dump_done=1 for exactly one cycle, dump_addr <- 0 (wraps) -> IDLE.
- Dump throughput: at most 1 word per 2 cycles.
- dump_start is ignored outside IDLE. A dump is never queued.
- rst asserted in any state aborts the dump immediately: no dump_done, outputs take reset values next cycle.
- dump_valid must never deassert without a transfer, except on rst.
- Arithmetic: dump_addr increments modulo 2^ADDR_WIDTH. No other arithmetic.

Test Plan:
- Defaults, reset, write then read: write mem[0x10]=0xA5 at cycle N, read 0x10 at N+1 -> rvalid=1 with rdata=0xA5 at N+2. rdata holds 0xA5 afterwards with rvalid=0.
- RD_LATENCY=3, back-to-back reads of 0x00..0x03 preloaded 0x11,0x22,0x33,0x44 -> rvalid high for 4 consecutive cycles starting 3 cycles after the first accept, data in order.
- Dump with dump_ready=1 constantly, memory preloaded mem[i]=i^0xFF:
  - 256 transfers with dump_addr 0..255 and dump_data = addr^0xFF.
  - dump_done pulses once, 1 cycle after the 0xFF transfer.
  - busy=1 from the cycle after dump_start through DONE.
- Backpressure: dump_ready held low 5 cycles at word 0x07 -> dump_valid stays 1, dump_addr=0x07, data unchanged. Transfer occurs on the cycle ready rises.
- Interaction: RD_LATENCY=2, read accepted in the same cycle as dump_start -> its rvalid still fires during DRAIN. A write req issued while busy=1 leaves mem unchanged, and a later dump shows the old value.
- Reset mid-dump at word 0x40 -> busy, dump_valid, dump_done all 0 next cycle, dump_addr=0, mem contents preserved. A subsequent dump_start restarts from 0x00.
